branch_unit: RTL and testbench

- Next-generation branch block: resolves conditional branches from raw operands and keeps a parametrised bimodal predictor (2-bit saturating counters).
- Flags mispredictions with a registered redirect.
- Sits in the EX stage; the predictor read port serves IF.
- One-cycle registered resolve path; table update and statistics counters are sequential.

---
 rtl/branch_unit.sv | 73 +++++++
 tb/tb_branch_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// branch_unit: EX-stage conditional branch resolver with bimodal 2-bit predictor and stats
// Ports: clk/reset (async, active-high); if_pc -> if_pred_taken (combinational lookup);
//   ex_* describe the EX branch (accepted when ex_valid & ~ex_flush);
//   res_* are one-cycle registered resolve pulses; stat_* count branches and mispredicts.
module branch_unit #(
  parameter int XLEN        = 64,
  parameter int PC_W        = 64,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic              ex_flush,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_rs1,
  input  logic [XLEN-1:0]   ex_rs2,
  input  logic [PC_W-1:0]   ex_target,
  input  logic              ex_pred_taken,
  output logic              res_valid,
  output logic              res_taken,
  output logic              res_mispredict,
  output logic [PC_W-1:0]   res_redirect_pc,
  output logic              res_illegal,
  output logic [CNT_W-1:0]  stat_branches,
  output logic [CNT_W-1:0]  stat_mispredicts
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  logic [1:0]       r_bht [BHT_ENTRIES];
  logic [IDX_W-1:0] w_if_idx, w_ex_idx;
  logic [1:0]       w_ctr, w_ctr_nxt;
  logic             w_cmp, w_illegal, w_taken, w_acc, w_mis;
  logic             w_unused_if;
  assign w_unused_if   = ^if_pc;
  assign w_if_idx      = if_pc[IDX_W+1:2];
  assign w_ex_idx      = ex_pc[IDX_W+1:2];
  assign if_pred_taken = r_bht[w_if_idx][1];
  always_comb begin
    w_cmp     = ex_funct3[2] ? (ex_funct3[1] ? (ex_rs1 < ex_rs2) : ($signed(ex_rs1) < $signed(ex_rs2)))
                             : (ex_rs1 == ex_rs2);
    w_illegal = ex_funct3[2:1] == 2'b01;
    w_taken   = !w_illegal && (w_cmp ^ ex_funct3[0]);
    w_acc     = ex_valid && !ex_flush;
    w_mis     = !w_illegal && (w_taken != ex_pred_taken);
    w_ctr     = r_bht[w_ex_idx];
    w_ctr_nxt = w_taken ? ((w_ctr == 2'b11) ? w_ctr : w_ctr + 2'd1)
                        : ((w_ctr == 2'b00) ? w_ctr : w_ctr - 2'd1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid        <= 1'b0;
      res_taken        <= 1'b0;
      res_mispredict   <= 1'b0;
      res_redirect_pc  <= '0;
      res_illegal      <= 1'b0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
    end else begin
      res_valid       <= w_acc;
      res_taken       <= w_acc && w_taken;
      res_mispredict  <= w_acc && w_mis;
      res_redirect_pc <= !w_acc ? '0 : w_taken ? ex_target : ex_pc + PC_W'(4);
      res_illegal     <= w_acc && w_illegal;
      if (w_acc) stat_branches <= stat_branches + CNT_W'(1);
      if (w_acc && w_mis) stat_mispredicts <= stat_mispredicts + CNT_W'(1);
      if (w_acc && !w_illegal) r_bht[w_ex_idx] <= w_ctr_nxt;
    end
  end
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: randomized + directed check of branch_unit against a behavioural model
module tb_branch_unit;
  localparam int N  = 16;
  localparam int CW = 4;
  logic          clk = 0, reset = 1;
  logic [63:0]   if_pc = 0, ex_pc = 0, ex_rs1 = 0, ex_rs2 = 0, ex_target = 0;
  logic          ex_valid = 0, ex_flush = 0, ex_pred_taken = 0;
  logic [2:0]    ex_funct3 = 0;
  logic          if_pred_taken, res_valid, res_taken, res_mispredict, res_illegal;
  logic [63:0]   res_redirect_pc;
  logic [CW-1:0] stat_branches, stat_mispredicts;
  int            pass_cnt = 0, total = 0;
  int            m_bht [N];
  logic [CW-1:0] m_br, m_mis;
  logic          e_valid, e_taken, e_mis, e_ill;
  logic [63:0]   e_pc;
  branch_unit #(.XLEN(64), .PC_W(64), .BHT_ENTRIES(N), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_flush(ex_flush), .ex_pc(ex_pc), .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
    .res_redirect_pc(res_redirect_pc), .res_illegal(res_illegal),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );
  always #5 clk = ~clk;
  function automatic int idx(input logic [63:0] pc);
    return int'((pc >> 2) % N);
  endfunction
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
  endtask
  task automatic model_reset();
    for (int i = 0; i < N; i++) m_bht[i] = 1;
    m_br = 0; m_mis = 0;
    e_valid = 0; e_taken = 0; e_mis = 0; e_ill = 0; e_pc = 0;
  endtask
  task automatic check_res();
    chk("res_valid", res_valid, e_valid);
    chk("res_taken", res_taken, e_taken);
    chk("res_mispredict", res_mispredict, e_mis);
    chk("res_redirect_pc", res_redirect_pc, e_pc);
    chk("res_illegal", res_illegal, e_ill);
    chk("stat_branches", stat_branches, m_br);
    chk("stat_mispredicts", stat_mispredicts, m_mis);
  endtask
  task automatic step(input logic v, input logic f, input logic [63:0] pc, input logic [2:0] f3,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] tgt,
                      input logic pt, input logic [63:0] ipc);
    logic c, ill, tk, acc;
    ex_valid = v; ex_flush = f; ex_pc = pc; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b;
    ex_target = tgt; ex_pred_taken = pt; if_pc = ipc;
    #1 chk("if_pred_taken", if_pred_taken, m_bht[idx(ipc)] >= 2);
    acc = v && !f;
    ill = f3[2:1] == 2'b01;
    case (f3[2:1])
      2'b00:   c = a == b;
      2'b10:   c = $signed(a) < $signed(b);
      2'b11:   c = a < b;
      default: c = 0;
    endcase
    tk = !ill && (c ^ f3[0]);
    e_valid = acc; e_taken = acc && tk; e_ill = acc && ill; e_mis = acc && !ill && (tk != pt);
    e_pc = !acc ? 64'd0 : tk ? tgt : pc + 64'd4;
    if (acc) begin
      m_br = m_br + 1'b1;
      if (e_mis) m_mis = m_mis + 1'b1;
      if (!ill) m_bht[idx(pc)] = tk ? (m_bht[idx(pc)] == 3 ? 3 : m_bht[idx(pc)] + 1)
                                    : (m_bht[idx(pc)] == 0 ? 0 : m_bht[idx(pc)] - 1);
    end
    @(posedge clk); #1 check_res();
  endtask
  task automatic do_reset();
    ex_valid = 0; reset = 1;
    #1 model_reset(); check_res();
    @(posedge clk); #1 reset = 0;
  endtask
  task automatic arst();
    #2 reset = 1;
    #1 model_reset(); check_res();
    @(posedge clk); #1 reset = 0;
    check_res();
  endtask
  function automatic logic [63:0] rv();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'($urandom_range(0, 3));
      default: return {$urandom, $urandom};
    endcase
  endfunction
  initial begin
    logic [63:0] ones, pc;
    ones = '1;
    model_reset();
    #2 check_res();
    #10 reset = 0;
    if_pc = 64'h100;
    #1 chk("lit reset pred", if_pred_taken, 0);
    step(1, 0, 64'h100, 3'b000, 5, 5, 64'h200, 0, 64'h100);
    chk("lit beq taken", res_taken, 1);
    chk("lit beq mis", res_mispredict, 1);
    chk("lit beq redirect", res_redirect_pc, 64'h200);
    chk("lit beq stat_mis", stat_mispredicts, 1);
    do_reset();
    step(1, 0, 64'h40, 3'b000, 7, 7, 64'h80, 0, 64'h40);
    chk("lit train 10", if_pred_taken, 1);
    step(1, 0, 64'h40, 3'b000, 7, 7, 64'h80, 1, 64'h40);
    step(1, 0, 64'h40, 3'b000, 1, 2, 64'h80, 1, 64'h40);
    chk("lit train 11->10", if_pred_taken, 1);
    step(1, 0, 64'h40, 3'b000, 1, 2, 64'h80, 1, 64'h40);
    chk("lit train 10->01", if_pred_taken, 0);
    step(1, 0, 64'h40, 3'b000, 1, 2, 64'h80, 0, 64'h40);
    step(1, 0, 64'h40, 3'b000, 1, 2, 64'h80, 0, 64'h40);
    step(1, 0, 64'h40, 3'b000, 3, 3, 64'h80, 0, 64'h40);
    chk("lit sat at 00", if_pred_taken, 0);
    step(1, 0, 64'h300, 3'b100, ones, 1, 64'h400, 0, 0);
    chk("lit blt", res_taken, 1);
    step(1, 0, 64'h300, 3'b110, ones, 1, 64'h400, 0, 0);
    chk("lit bltu", res_taken, 0);
    chk("lit bltu redirect", res_redirect_pc, 64'h304);
    step(1, 0, 64'h300, 3'b101, ones, 1, 64'h400, 0, 0);
    chk("lit bge", res_taken, 0);
    step(1, 0, 64'h300, 3'b111, ones, 1, 64'h400, 0, 0);
    chk("lit bgeu", res_taken, 1);
    step(1, 0, 64'h40, 3'b010, 4, 4, 64'h80, 1, 64'h40);
    chk("lit illegal", res_illegal, 1);
    chk("lit illegal taken", res_taken, 0);
    chk("lit illegal mis", res_mispredict, 0);
    chk("lit illegal no update", if_pred_taken, 0);
    step(1, 1, 64'h40, 3'b000, 4, 4, 64'h80, 0, 64'h40);
    chk("lit flush valid", res_valid, 0);
    chk("lit flush no update", if_pred_taken, 0);
    do_reset();
    step(1, 0, 64'h80, 3'b000, 3, 3, 64'h90, 0, 64'h80);
    chk("lit rbw post", if_pred_taken, 1);
    chk("lit pulse valid", res_valid, 1);
    ex_valid = 1;
    #2 reset = 1;
    #1 chk("lit arst valid", res_valid, 0);
    chk("lit arst stat", stat_branches, 0);
    for (int k = 0; k < 4; k++) begin
      if_pc = 64'(k * 4 + 64'h80);
      #1 chk("lit arst pred", if_pred_taken, 0);
    end
    model_reset();
    @(posedge clk); #1 reset = 0;
    check_res();
    for (int k = 0; k < 16; k++) step(1, 0, 64'(k * 4), 3'b001, 1, 2, 64'h10, 1, 0);
    chk("lit stat wrap", stat_branches, 0);
    for (int n = 0; n < 3000; n++) begin
      pc = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : 64'($urandom_range(0, 63) * 4);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, pc, 3'($urandom_range(0, 7)),
           rv(), rv(), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 64'($urandom_range(0, 63) * 4));
      if ($urandom_range(0, 199) == 0) arst();
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
